// File: rtl/dest_sel_pipe_if.sv
// Bundle of decode-side inputs and hazard/write-back outputs of dest_sel_pipe.
// The pipe takes the slave modport; whoever drives decode takes the master modport.
interface dest_sel_pipe_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3
);
    logic [AW-1:0]       rd_r;
    logic [AW-1:0]       rd_i;
    logic [1:0]          dst_sel;
    logic                we_in;
    logic                stall;
    logic                flush;
    logic [AW-1:0]       src_a;
    logic [AW-1:0]       src_b;
    logic [DEPTH-1:0]    hit_a;
    logic [DEPTH-1:0]    hit_b;
    logic [DEPTH*AW-1:0] stage_dest;
    logic [DEPTH-1:0]    stage_we;
    logic [AW-1:0]       dest_o;
    logic                we_o;

    modport master (
        output rd_r, rd_i, dst_sel, we_in, stall, flush, src_a, src_b,
        input  hit_a, hit_b, stage_dest, stage_we, dest_o, we_o
    );

    modport slave (
        input  rd_r, rd_i, dst_sel, we_in, stall, flush, src_a, src_b,
        output hit_a, hit_b, stage_dest, stage_we, dest_o, we_o
    );
endinterface

// File: rtl/dest_sel_pipe.sv
// Destination-register select plus a DEPTH-stage shift register of {dest, we}.
// Per-stage source-address match vectors feed the hazard and forwarding unit.
module dest_sel_pipe #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input logic             clk,
    input logic             reset,
    dest_sel_pipe_if.slave  bus
);
    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    logic [DEPTH-1:0][AW-1:0] dest_q;
    logic [DEPTH-1:0]         we_q;
    logic [AW-1:0]            sel_addr;
    logic [AW-1:0]            cap_dest;
    logic                     cap_we;

    // Register 0 is never tracked as a write, so its dest is zeroed too.
    always_comb begin
        sel_addr = '0;
        case (bus.dst_sel)
            2'b00:   sel_addr = bus.rd_r;
            2'b01:   sel_addr = bus.rd_i;
            2'b10:   sel_addr = LINK_ADDR;
            default: sel_addr = '0;
        endcase
        cap_we   = bus.we_in && (bus.dst_sel != 2'b11) && (sel_addr != '0);
        cap_dest = cap_we ? sel_addr : '0;
    end

    // A flush clears stage 0 even during a stall; the older stages only follow the stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q <= '0;
            we_q   <= '0;
        end else begin
            if (!bus.stall) begin
                for (int k = 1; k < DEPTH; k++) begin
                    dest_q[k] <= dest_q[k-1];
                    we_q[k]   <= we_q[k-1];
                end
            end
            if (bus.flush) begin
                dest_q[0] <= '0;
                we_q[0]   <= 1'b0;
            end else if (!bus.stall) begin
                dest_q[0] <= cap_dest;
                we_q[0]   <= cap_we;
            end
        end
    end

    always_comb begin
        bus.hit_a = '0;
        bus.hit_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.hit_a[k] = we_q[k] && (dest_q[k] == bus.src_a) && (bus.src_a != '0);
            bus.hit_b[k] = we_q[k] && (dest_q[k] == bus.src_b) && (bus.src_b != '0);
        end
    end

    assign bus.stage_dest = dest_q;
    assign bus.stage_we   = we_q;
    assign bus.dest_o     = dest_q[DEPTH-1];
    assign bus.we_o       = we_q[DEPTH-1];
endmodule

// File: tb/tb_dest_sel_pipe.sv
// Directed bench for dest_sel_pipe: a history-queue model checked every cycle
// plus literal expectations for mode select, latency, hazards, stall/flush and reset.
module tb_dest_sel_pipe;
    localparam int AW       = 5;
    localparam int DEPTH    = 3;
    localparam int LINK_REG = 31;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dest_sel_pipe_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    dest_sel_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(LINK_REG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic          we;
    } entry_t;

    // hist[0] is the youngest entry; missing entries read as empty.
    entry_t hist[$];
    bit     model_live = 1'b0;

    function automatic entry_t captured(logic [AW-1:0] rd_r, logic [AW-1:0] rd_i,
                                        logic [1:0] sel, logic we);
        entry_t e;
        int addr;
        case (sel)
            2'd0:    addr = int'(rd_r);
            2'd1:    addr = int'(rd_i);
            2'd2:    addr = LINK_REG % (1 << AW);
            default: addr = 0;
        endcase
        e.we   = we && (sel != 2'd3) && (addr != 0);
        e.dest = e.we ? AW'(addr) : '0;
        return e;
    endfunction

    function automatic entry_t stage(int k);
        entry_t z;
        z = '0;
        if (k < hist.size()) return hist[k];
        return z;
    endfunction

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            if (!bus.stall) begin
                hist.push_front(bus.flush ? entry_t'('0)
                                          : captured(bus.rd_r, bus.rd_i, bus.dst_sel, bus.we_in));
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end else if (bus.flush && hist.size() > 0) begin
                hist[0] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic [DEPTH*AW-1:0] exp_dest;
            logic [DEPTH-1:0]    exp_we, exp_ha, exp_hb;
            for (int k = 0; k < DEPTH; k++) begin
                entry_t e;
                e = stage(k);
                exp_dest[k*AW +: AW] = e.dest;
                exp_we[k] = e.we;
                exp_ha[k] = e.we && (e.dest == bus.src_a) && (bus.src_a != 0);
                exp_hb[k] = e.we && (e.dest == bus.src_b) && (bus.src_b != 0);
            end
            check_output("model_stage_dest", 32'(bus.stage_dest), 32'(exp_dest));
            check_output("model_stage_we",   32'(bus.stage_we),   32'(exp_we));
            check_output("model_hit_a",      32'(bus.hit_a),      32'(exp_ha));
            check_output("model_hit_b",      32'(bus.hit_b),      32'(exp_hb));
            check_output("model_dest_o",     32'(bus.dest_o),     32'(exp_dest[(DEPTH-1)*AW +: AW]));
            check_output("model_we_o",       32'(bus.we_o),       32'(exp_we[DEPTH-1]));
        end
    end

    task automatic apply_stimulus(input logic [AW-1:0] rd_r, input logic [AW-1:0] rd_i,
                                  input logic [1:0] sel, input logic we,
                                  input logic stl, input logic fls,
                                  input logic [AW-1:0] sa, input logic [AW-1:0] sb);
        bus.rd_r    = rd_r;
        bus.rd_i    = rd_i;
        bus.dst_sel = sel;
        bus.we_in   = we;
        bus.stall   = stl;
        bus.flush   = fls;
        bus.src_a   = sa;
        bus.src_b   = sb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(AW'($urandom), AW'($urandom), 2'($urandom), 1'b1, 1'b0, 1'b0,
                       AW'($urandom), AW'($urandom));
        tick();
        apply_stimulus(AW'($urandom), AW'($urandom), 2'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                       5'd31, 5'd7);
        tick();
        check_output("reset_stage_dest", 32'(bus.stage_dest), 32'd0);
        check_output("reset_stage_we",   32'(bus.stage_we),   32'd0);
        check_output("reset_dest_o",     32'(bus.dest_o),     32'd0);
        check_output("reset_hit_a",      32'(bus.hit_a),      32'd0);

        reset = 1'b0;
        apply_stimulus(5'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4);
        repeat (5) tick();
        check_output("idle_stage_we", 32'(bus.stage_we), 32'd0);
        check_output("idle_we_o",     32'(bus.we_o),     32'd0);

        // Mode select and latency
        apply_stimulus(5'd5, 5'd9, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("mode_rd_r_s0", 32'(bus.stage_dest[0 +: AW]), 32'd5);
        apply_stimulus(5'd5, 5'd9, 2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("mode_rd_i_s0", 32'(bus.stage_dest[0 +: AW]), 32'd9);
        apply_stimulus(5'd5, 5'd9, 2'd2, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("mode_link_s0", 32'(bus.stage_dest[0 +: AW]), 32'd31);
        check_output("latency_dest_o", 32'(bus.dest_o), 32'd5);
        check_output("latency_we_o",   32'(bus.we_o),   32'd1);
        apply_stimulus(5'd5, 5'd9, 2'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("mode_none_s0",    32'(bus.stage_dest[0 +: AW]), 32'd0);
        check_output("mode_none_we0",   32'(bus.stage_we[0]),         32'd0);
        check_output("latency2_dest_o", 32'(bus.dest_o),              32'd9);
        apply_stimulus(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("latency3_dest_o", 32'(bus.dest_o), 32'd31);
        tick();
        check_output("none_exit_we_o",   32'(bus.we_o),   32'd0);
        check_output("none_exit_dest_o", 32'(bus.dest_o), 32'd0);

        // Register 0 suppression
        apply_stimulus(5'd0, 5'd6, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        check_output("reg0_we0", 32'(bus.stage_we[0]), 32'd0);
        check_output("reg0_hit_a", 32'(bus.hit_a), 32'd0);

        // Hazard match: 7/live, 7/dead (zeroed), 7/live
        apply_stimulus(5'd7, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        apply_stimulus(5'd7, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        apply_stimulus(5'd7, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd3);
        tick();
        apply_stimulus(5'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd3);
        #1;
        check_output("hazard_hit_a", 32'(bus.hit_a), 32'b101);
        check_output("hazard_hit_b", 32'(bus.hit_b), 32'b000);
        bus.src_a = 5'd3;
        #1;
        check_output("hazard_hit_a_comb", 32'(bus.hit_a), 32'b000);
        bus.src_b = 5'd7;
        #1;
        check_output("hazard_hit_b_comb", 32'(bus.hit_b), 32'b101);
        tick();

        // Stall/flush interaction with stages {4,6,8}
        apply_stimulus(5'd8, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd4);
        tick();
        apply_stimulus(5'd6, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd4);
        tick();
        apply_stimulus(5'd4, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd4);
        tick();
        apply_stimulus(5'd17, 5'd18, 2'd0, 1'b1, 1'b1, 1'b0, 5'd6, 5'd4);
        repeat (3) tick();
        check_output("stall_hold_dest", 32'(bus.stage_dest), 32'({5'd8, 5'd6, 5'd4}));
        check_output("stall_hold_we",   32'(bus.stage_we),   32'b111);
        apply_stimulus(5'd17, 5'd18, 2'd0, 1'b1, 1'b1, 1'b1, 5'd6, 5'd4);
        tick();
        check_output("stall_flush_dest", 32'(bus.stage_dest), 32'({5'd8, 5'd6, 5'd0}));
        check_output("stall_flush_we",   32'(bus.stage_we),   32'b110);
        apply_stimulus(5'd12, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 5'd6, 5'd12);
        tick();
        check_output("flush_shift_dest", 32'(bus.stage_dest), 32'({5'd6, 5'd0, 5'd0}));
        check_output("flush_shift_we",   32'(bus.stage_we),   32'b100);
        check_output("flush_shift_dest_o", 32'(bus.dest_o),   32'd6);

        // Reset mid-operation overrides stall and flush
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(AW'(i), 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3);
            tick();
        end
        reset = 1'b1;
        apply_stimulus(5'd10, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3);
        tick();
        check_output("midreset_dest", 32'(bus.stage_dest), 32'd0);
        check_output("midreset_we",   32'(bus.stage_we),   32'd0);
        reset = 1'b0;
        apply_stimulus(5'd10, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd10, 5'd0);
        tick();
        apply_stimulus(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd10, 5'd0);
        tick();
        check_output("postreset_not_yet", 32'(bus.we_o), 32'd0);
        tick();
        check_output("postreset_dest_o", 32'(bus.dest_o), 32'd10);
        check_output("postreset_we_o",   32'(bus.we_o),   32'd1);
        check_output("postreset_hit_a",  32'(bus.hit_a),  32'b100);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
